// File: rtl/move_fifo_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : move_fifo_sched_pkg
// Description : Shared constants for the move-code FIFO scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package move_fifo_sched_pkg;

    localparam int c_DW        = 2;
    localparam int c_DEPTH_DEF = 16;
    localparam int c_PACE_DEF  = 4;

    // 2-bit face-turn move codes carried through the FIFO
    localparam logic [1:0] c_MOVE_CW   = 2'd0;
    localparam logic [1:0] c_MOVE_CCW  = 2'd1;
    localparam logic [1:0] c_MOVE_HALF = 2'd2;
    localparam logic [1:0] c_MOVE_NONE = 2'd3;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_POP  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/move_fifo_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : move_fifo_sched_if
// Description : Producer-side valid/ready bundle for the move scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface move_fifo_sched_if
    import move_fifo_sched_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = c_DW
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_data, output req_ready);

endinterface
`default_nettype wire

// File: rtl/move_fifo_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick of the first request at or
//               after ptr; block suppresses every grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import move_fifo_sched_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic [NREQ-1:0]  req,
    input  wire logic [PTR_W-1:0] ptr,
    input  wire logic             block,
    output logic      [NREQ-1:0]  gnt,
    output logic      [PTR_W-1:0] idx
);

    int w_best;
    int w_sel;
    int w_dist;

    // Pick the valid requester with the smallest rotational distance from ptr
    always_comb begin
        w_best = NREQ;
        w_sel  = 0;
        w_dist = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NREQ - int'(ptr));
            if (req[i] && !block && (w_dist < w_best)) begin
                w_best = w_dist;
                w_sel  = i;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = (w_best < NREQ) && (w_sel == i);
        end
        idx = w_sel[PTR_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/move_fifo_sched.sv
`default_nettype none
// ============================================================================
// Module      : move_fifo_sched
// Description : Arbitrates producers onto the move FIFO write port and paces
//               reads while tracking committed occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module move_fifo_sched
    import move_fifo_sched_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int DW    = c_DW,
    parameter int DEPTH = c_DEPTH_DEF,
    parameter int CNT_W = 5,
    parameter int PACE  = c_PACE_DEF
) (
    input  wire logic          clk,
    input  wire logic          reset,
    move_fifo_sched_if.slave   req_if,
    input  wire logic          enable,
    input  wire logic          cons_ready,
    output logic               fifo_wr,
    output logic [DW-1:0]      fifo_din,
    output logic               fifo_rd,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int c_PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_PACE_W = $clog2(PACE + 1);
    localparam logic [c_PACE_W-1:0] c_PACE_LOAD = c_PACE_W'(PACE - 2);

    logic [c_PTR_W-1:0]  r_ptr;
    logic [1:0]          r_state;
    logic [c_PACE_W-1:0] r_pace;
    logic [CNT_W-1:0]    r_count;
    logic                r_fifo_wr;
    logic [DW-1:0]       r_fifo_din;
    logic                r_fifo_rd;

    logic [NREQ-1:0]     w_gnt;
    logic [c_PTR_W-1:0]  w_idx;
    logic                w_full;
    logic                w_xfer;
    logic                w_pop;
    logic [DW-1:0]       w_data;

    assign w_full = (r_count == CNT_W'(DEPTH));

    // Reset gates the grant so producers never see ready while state is clearing
    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (c_PTR_W)
    ) u_rr_arbiter (
        .req   (req_if.req_valid),
        .ptr   (r_ptr),
        .block (w_full | reset),
        .gnt   (w_gnt),
        .idx   (w_idx)
    );

    assign req_if.req_ready = w_gnt;
    assign w_xfer           = |w_gnt;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_data = req_if.req_data[i*DW +: DW];
            end
        end
    end

    // The in-flight write is excluded so a pop never overtakes its own write
    assign w_pop = (r_state == c_ST_IDLE) && enable && cons_ready &&
                   (r_count > CNT_W'(r_fifo_wr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_fifo_wr  <= 1'b0;
            r_fifo_din <= c_MOVE_CW;
        end else begin
            r_fifo_wr <= w_xfer;
            if (w_xfer) begin
                r_fifo_din <= w_data;
                r_ptr      <= (w_idx == c_PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end
            case ({w_xfer, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_pace    <= '0;
            r_fifo_rd <= 1'b0;
        end else begin
            r_fifo_rd <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_state   <= c_ST_POP;
                        r_fifo_rd <= 1'b1;
                    end
                end
                c_ST_POP: begin
                    r_pace  <= c_PACE_LOAD;
                    r_state <= (PACE > 2) ? c_ST_WAIT : c_ST_IDLE;
                end
                c_ST_WAIT: begin
                    if (r_pace <= c_PACE_W'(1)) begin
                        r_pace  <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_pace <= r_pace - 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign fifo_wr  = r_fifo_wr;
    assign fifo_din = r_fifo_din;
    assign fifo_rd  = r_fifo_rd;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_move_fifo_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_fifo_sched
// Description : Self-checking bench for move_fifo_sched with an occupancy and
//               pacing model plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_fifo_sched;
    import move_fifo_sched_pkg::*;

    localparam int NREQ  = 3;
    localparam int DW    = 2;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;
    localparam int PACE  = 4;

    logic             clk        = 1'b0;
    logic             reset      = 1'b1;
    logic             enable     = 1'b0;
    logic             cons_ready = 1'b0;
    logic             fifo_wr;
    logic [DW-1:0]    fifo_din;
    logic             fifo_rd;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    move_fifo_sched_if #(.NREQ(NREQ), .DW(DW)) req_if ();

    move_fifo_sched #(
        .NREQ  (NREQ),
        .DW    (DW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PACE  (PACE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_if     (req_if),
        .enable     (enable),
        .cons_ready (cons_ready),
        .fifo_wr    (fifo_wr),
        .fifo_din   (fifo_din),
        .fifo_rd    (fifo_rd),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: committed occupancy, RR pointer, pending write, pacing
    int m_ptr   = 0;
    int m_count = 0;
    int m_wr    = 0;
    int m_din   = 0;
    int m_rd    = 0;
    int m_last  = -1000;
    int m_cyc   = 0;
    int m_g;
    int m_pop;
    logic [NREQ-1:0]    m_rdy;
    logic [NREQ*DW-1:0] m_sh;

    always @(negedge clk) begin
        if (reset) begin
            m_ptr = 0; m_count = 0; m_wr = 0; m_rd = 0; m_last = -1000; m_cyc = 0;
            check("m_rst_ready", 32'(req_if.req_ready), 0);
            check("m_rst_wr", 32'(fifo_wr), 0);
            check("m_rst_rd", 32'(fifo_rd), 0);
            check("m_rst_count", 32'(count), 0);
            check("m_rst_empty", 32'(empty), 1);
            check("m_rst_full", 32'(full), 0);
        end else begin
            m_g = -1;
            if (m_count < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_g < 0 && ((req_if.req_valid >> ((m_ptr + k) % NREQ)) & 1) != 0)
                        m_g = (m_ptr + k) % NREQ;
                end
            end
            m_rdy = (m_g >= 0) ? (NREQ'(1) << m_g) : '0;
            check("m_ready", 32'(req_if.req_ready), 32'(m_rdy));
            check("m_wr", 32'(fifo_wr), 32'(m_wr));
            if (m_wr != 0) check("m_din", 32'(fifo_din), 32'(m_din));
            check("m_rd", 32'(fifo_rd), 32'(m_rd));
            check("m_count", 32'(count), 32'(m_count));
            check("m_full", 32'(full), 32'(m_count == DEPTH));
            check("m_empty", 32'(empty), 32'(m_count == 0));
            m_pop = (enable && cons_ready && (m_count - m_wr) >= 1 &&
                     (m_cyc - m_last) >= PACE) ? 1 : 0;
            m_count = m_count + ((m_g >= 0) ? 1 : 0) - m_pop;
            m_wr    = (m_g >= 0) ? 1 : 0;
            if (m_g >= 0) begin
                m_sh  = req_if.req_data >> (m_g * DW);
                m_din = int'(m_sh[DW-1:0]);
                m_ptr = (m_g + 1) % NREQ;
            end
            m_rd = m_pop;
            if (m_pop != 0) m_last = m_cyc;
            m_cyc++;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    logic [NREQ-1:0] exp_rr [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int n_wr;
    int q_rd[$];
    int wr_c;
    int rd_c;
    int seen;

    initial begin
        req_if.req_valid = '0;
        req_if.req_data  = '0;
        repeat (3) begin
            cyc();
            req_if.req_valid = NREQ'($urandom);
            req_if.req_data  = (NREQ*DW)'($urandom);
        end
        smp();
        check("rst_ready", 32'(req_if.req_ready), 0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);

        // Single write from requester 0
        cyc(); reset = 1'b0; req_if.req_valid = 3'b001; req_if.req_data = 6'b000001;
        smp(); check("sw_ready", 32'(req_if.req_ready), 32'h1);
        cyc(); req_if.req_valid = '0;
        smp();
        check("sw_wr", 32'(fifo_wr), 1);
        check("sw_din", 32'(fifo_din), 1);
        check("sw_count", 32'(count), 1);
        check("sw_empty", 32'(empty), 0);

        // Round robin until full
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; req_if.req_valid = 3'b111; req_if.req_data = {2'd3, 2'd2, 2'd1};
        n_wr = 0;
        for (int c = 0; c < 20; c++) begin
            smp();
            if (c < 4) check($sformatf("rr_gnt%0d", c), 32'(req_if.req_ready), 32'(exp_rr[c]));
            n_wr += int'(fifo_wr);
            cyc();
        end
        smp();
        check("rr_count", 32'(count), 16);
        check("rr_full", 32'(full), 1);
        check("rr_ready", 32'(req_if.req_ready), 0);
        check("rr_nwr", 32'(n_wr), 16);

        // Paced drain from five entries
        cyc(); req_if.req_valid = '0; reset = 1'b1;
        cyc(); reset = 1'b0; req_if.req_valid = 3'b001; req_if.req_data = 6'b000010;
        repeat (5) cyc();
        req_if.req_valid = '0;
        repeat (2) cyc();
        enable = 1'b1; cons_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            smp();
            if (fifo_rd) q_rd.push_back(c);
            cyc();
        end
        check("dr_npulse", 32'(q_rd.size()), 5);
        if (q_rd.size() == 5) begin
            check("dr_first", 32'(q_rd[0]), 1);
            for (int i = 1; i < 5; i++)
                check($sformatf("dr_gap%0d", i), 32'(q_rd[i] - q_rd[0]), 32'(4 * i));
        end
        smp();
        check("dr_count", 32'(count), 0);
        check("dr_empty", 32'(empty), 1);

        // Read never precedes its write
        cyc(); req_if.req_valid = 3'b001; req_if.req_data = 6'b000011;
        wr_c = -1; rd_c = -1;
        for (int c = 0; c < 10; c++) begin
            smp();
            if (fifo_wr && wr_c < 0) wr_c = c;
            if (fifo_rd && rd_c < 0) rd_c = c;
            cyc();
            if (c == 0) req_if.req_valid = '0;
        end
        check("ord_wr", 32'(wr_c), 1);
        check("ord_rd", 32'(rd_c), 3);

        // Transfer and pop decision in the same cycle at count 8
        enable = 1'b0; req_if.req_valid = 3'b001;
        repeat (8) cyc();
        req_if.req_valid = '0;
        repeat (2) cyc();
        smp(); check("c8_pre", 32'(count), 8);
        cyc(); enable = 1'b1; req_if.req_valid = 3'b001;
        smp(); check("c8_same", 32'(count), 8);
        cyc(); req_if.req_valid = '0; enable = 1'b0;
        smp(); check("c8_post", 32'(count), 8);

        // Reset during WAIT
        repeat (6) cyc();
        enable = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            smp();
            if (fifo_rd) seen = 1;
            else cyc();
        end
        check("wt_rd_seen", 32'(seen), 1);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        check("wt_rd", 32'(fifo_rd), 0);
        check("wt_count", 32'(count), 0);
        check("wt_empty", 32'(empty), 1);
        repeat (2) cyc();
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            smp();
            if (fifo_rd) seen++;
            cyc();
        end
        check("wt_no_rd", 32'(seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/move_fifo_sched.md
Name: move_fifo_sched

Overview:
- Scheduler in front of the 2-bit move-code FIFO in the cube controller.
- Round-robin arbitrates up to NREQ producers (e.g. sequence ROM, solver, manual keypad) onto the single FIFO write port.
- Paces FIFO reads for the motor/consumer side and tracks occupancy so the FIFO never overflows or underflows.

Parameters:
- NREQ, 3, number of requesters.
- DW, 2, move-code width (matches the FIFO din).
- DEPTH, 16, FIFO capacity in entries.
- CNT_W, 5, occupancy counter width; must hold DEPTH.
- PACE, 4, minimum cycles between consecutive fifo_rd pulses (>=2).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  NREQ  per-requester move valid.
- req_data  in  NREQ*DW  packed move codes; requester i uses bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant. Combinational from req_valid, the RR pointer and full. Transfer occurs when valid&ready.
- enable  in  1  read-side enable.
- cons_ready  in  1  consumer can accept a move.
- fifo_wr  out  1  registered write strobe to the FIFO.
- fifo_din  out  DW  registered write data.
- fifo_rd  out  1  registered one-cycle read strobe.
- count  out  CNT_W  committed occupancy; includes a write in flight.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset values: fifo_wr=0, fifo_din=0, fifo_rd=0, count=0, full=0, empty=1, RR pointer=0, FSM=IDLE, pace counter=0. req_ready=0 while reset is high.
- Arbitration:
  - The first valid requester at or after the pointer (mod NREQ) gets req_ready.
  - No grant when full=1 or no valid is high.
  - After a transfer from requester i, the pointer becomes (i+1) mod NREQ. Without a transfer the pointer holds.
- Write latency: a transfer in cycle N gives fifo_wr=1 and fifo_din=data in cycle N+1. fifo_wr is 0 otherwise. Maximum one write per cycle.
- Occupancy: count +1 on a transfer and -1 on a pop decision, both taking effect at the end of that cycle. Both in the same cycle leaves count unchanged.
- Avail = count minus the in-flight write (fifo_wr currently high ? 1 : 0). A pop is allowed only when avail>=1, so a read never precedes its write.
- Read FSM (IDLE, POP, WAIT):
  - IDLE: if enable && cons_ready && avail>=1, go to POP and decrement count.
  - POP: fifo_rd=1 for exactly this cycle; load the pace counter with PACE-2; go to WAIT.
  - WAIT: decrement the pace counter; at 0 go to IDLE. This gives at most one pop per PACE cycles.
  - enable or cons_ready dropping during POP/WAIT does not abort; the sequence completes and is then re-evaluated in IDLE.
- Writes are independent of enable.
- Boundaries:
  - full blocks all grants.
  - A transfer and a pop decision in the same cycle at count==DEPTH cannot occur, because grants are blocked when full.
  - count never wraps below 0 or above DEPTH.
- Reset mid-operation: any state, including WAIT or a pending write, returns asynchronously to the reset values. A pending fifo_wr is dropped. The FIFO must share the same reset so both sides agree on empty.

Decomposition:
- Shared package holds:
  - DW and the move-code constants (2-bit encoding).
  - The FSM state encoding: IDLE=2'd0, POP=2'd1, WAIT=2'd2.
  - The default DEPTH and PACE constants.
- Sub-module rr_arbiter (parameter NREQ): inputs req, ptr, block; outputs one-hot gnt and granted index. It is purely combinational; the pointer register stays in move_fifo_sched.

Test Plan:
- Reset: hold reset with random req_valid -> req_ready=000, fifo_wr=0, fifo_rd=0, count=0, empty=1, full=0. Assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- Single write: req_valid=001, req_data[1:0]=2'b01 for one cycle -> req_ready=001 that cycle; next cycle fifo_wr=1, fifo_din=01, count=1, empty=0.
- Round-robin and full: req_valid=111 held, pointer=0 -> grants 001,010,100,001,... one per cycle. After 16 transfers, count=16, full=1, req_ready=000, and there are exactly 16 fifo_wr pulses.
- Paced drain: count=5, enable=1, cons_ready=1, no writes -> fifo_rd pulses on cycles t, t+4, t+8, t+12, t+16. Then count=0, empty=1, no further pulses.
- Write/read ordering: count=0, single transfer at cycle N with enable=cons_ready=1 -> fifo_wr at N+1; fifo_rd no earlier than N+2. Separately, at count=8, a transfer and a pop decision in the same cycle -> count stays 8.
- Reset during WAIT: pop issued, reset asserted 2 cycles later -> FSM=IDLE, count=0, fifo_rd=0 immediately. After release with count=0, no fifo_rd occurs.
